// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath constants and window tap addressing.
package cnn_pkg;
   localparam int DATA_WIDTH    = 8;
   localparam int CONV_SIZE     = 9;
   localparam int INPUT_CHANNEL = 3;
   localparam int PIX_W         = INPUT_CHANNEL * DATA_WIDTH;

   // Bit offset of channel c of tap t in a window of C-channel pixels.
   function automatic int tap_offset(input int t, input int c, input int C);
      return (t * C + c) * DATA_WIDTH;
   endfunction
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one-row pixel store with a read-before-write port at a shared address.
module line_buffer #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic                     clk_i,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk_i)
      if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster RGB pixel stream into 3x3 sliding windows
// (valid-only, stride 1) using two chained line buffers and a register window.
module conv_window_gen #(
   parameter int IMG_W         = 8,
   parameter int IMG_H         = 8,
   parameter int INPUT_CHANNEL = 3,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                                   clk_i,
   input  logic                                   rst_n,
   input  logic [INPUT_CHANNEL*DATA_WIDTH-1:0]    pix_i,
   input  logic                                   pix_valid_i,
   output logic                                   pix_ready_o,
   output logic [9*INPUT_CHANNEL*DATA_WIDTH-1:0]  win_o,
   output logic                                   win_valid_o,
   input  logic                                   win_ready_i,
   output logic                                   frame_done_o
);
   import cnn_pkg::*;

   localparam int PX_W = INPUT_CHANNEL * DATA_WIDTH;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);

   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;
   logic [PX_W-1:0] r_win   [CONV_SIZE];
   logic [PX_W-1:0] w_shift [CONV_SIZE];
   logic            r_win_valid;
   logic            r_frame_done;
   logic [PX_W-1:0] w_lb0;
   logic [PX_W-1:0] w_lb1;
   logic            w_accept;
   logic            w_emit;
   logic            w_last_col;
   logic            w_last_row;

   assign pix_ready_o  = !r_win_valid || win_ready_i;
   assign w_accept     = pix_valid_i && pix_ready_o;
   assign w_last_col   = r_col == CW'(IMG_W - 1);
   assign w_last_row   = r_row == RW'(IMG_H - 1);
   // Column gate also hides the stale left columns left over from the previous row.
   assign w_emit       = r_row >= RW'(2) && r_col >= CW'(2);
   assign win_valid_o  = r_win_valid;
   assign frame_done_o = r_frame_done;

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb0 (
      .clk_i   (clk_i),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (pix_i),
      .o_rdata (w_lb0)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PX_W)) u_lb1 (
      .clk_i   (clk_i),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_lb0),
      .o_rdata (w_lb1)
   );

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         w_shift[3*k]   = r_win[3*k+1];
         w_shift[3*k+1] = r_win[3*k+2];
      end
      w_shift[2] = w_lb1;
      w_shift[5] = w_lb0;
      w_shift[8] = pix_i;
   end

   for (genvar t = 0; t < CONV_SIZE; t++) begin : g_tap
      for (genvar c = 0; c < INPUT_CHANNEL; c++) begin : g_ch
         assign win_o[tap_offset(t, c, INPUT_CHANNEL) +: DATA_WIDTH] = r_win[t][c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Window regs only move on accept, which backpressure blocks, so win_o holds while stalled.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_win        <= '{default: '0};
      end else begin
         r_frame_done <= w_accept && w_last_col && w_last_row;
         if (w_accept) begin
            r_win       <= w_shift;
            r_win_valid <= w_emit;
            r_col       <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
         end else if (win_ready_i) begin
            r_win_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for conv_layer: converts a raster-order RGB pixel stream into 3x3xINPUT_CHANNEL sliding windows.
- Uses two on-chip line buffers and a 3x3 register window; valid-only convolution (no padding), stride 1.
- The output window is CONV_SIZE*INPUT_CHANNEL*8 bits. Downstream logic replicates it across the NUM_OF_FILTERS slices of conv_layer in_data.

Parameters:
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (>=3).
- INPUT_CHANNEL, 3, channels per pixel.
- DATA_WIDTH, 8, bits per channel sample.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- pix_i  in  INPUT_CHANNEL*DATA_WIDTH  pixel; channel c at [c*8 +: 8].
- pix_valid_i  in  1  pixel offered.
- pix_ready_o  out  1  pixel accepted when valid&&ready.
- win_o  out  9*INPUT_CHANNEL*DATA_WIDTH  window.
- win_valid_o  out  1  window held valid.
- win_ready_i  in  1  downstream accepts window.
- frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (clk_i edge with rst_n=0): win_o=0, win_valid_o=0, frame_done_o=0, col=0, row=0, window regs=0. Line-buffer contents are don't-care.
- pix_ready_o = !win_valid_o || win_ready_i. This is combinational, one-deep output skid.
- Accept = pix_valid_i && pix_ready_o. On accept of pixel P at (row,col):
  - Window shifts left one column. New right column is {top=lb1[col], mid=lb0[col], bottom=P}.
  - lb1[col] <= lb0[col]; lb0[col] <= P.
  - col increments. At IMG_W-1, col wraps to 0 and row increments. At IMG_H-1 with col at IMG_W-1, row wraps to 0 and frame_done_o pulses the next cycle.
- Window emit: if the accepted pixel has row>=2 && col>=2, then next cycle win_valid_o=1 and win_o = the shifted window. Latency is 1 cycle from accept.
- Accept without emit: win_valid_o clears if win_ready_i was 1, otherwise it holds.
- win_o/win_valid_o are stable while win_valid_o && !win_ready_i.
- Window packing: tap t = ky*3+kx, with ky=0 the oldest row and kx=0 the leftmost column. Sample (t,c) sits at [(t*INPUT_CHANNEL+c)*8 +: 8], matching the conv_RGB slice order.
- Stale columns after a row wrap are never emitted, because col>=2 gates emission.
- Frames run back-to-back with no bubble. The first two rows of a new frame emit nothing, even though the line buffers hold the previous frame.
- Outputs per frame: exactly (IMG_W-2)*(IMG_H-2).
- Reset mid-frame:
  - Counters and outputs clear. Any pending window is dropped.
  - The next accepted pixel is (0,0).
  - No window is emitted until row 2, col 2 of the new frame.
- pix_valid_i low: no state change. A held window persists.

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH=8 and CONV_SIZE=9.
  - Function tap_offset(t,c,C) returning the bit offset.
  - Localparam PIX_W=INPUT_CHANNEL*DATA_WIDTH.
- Sub-module line_buffer (depth IMG_W, width PIX_W, one write port and one read port at the same address, read-before-write). Instantiate it twice, chained lb0->lb1.
- Counters, window registers and handshake stay in conv_window_gen.

Test Plan:
- IMG_W=4, IMG_H=4, C=3, pixel n = {n,n,n}, win_ready_i=1, continuous valid:
  - First win_valid_o is the cycle after pixel 10 is accepted.
  - Taps t0..t8 = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 windows, with centres 5,6,9,10.
- Same stream with win_ready_i=0 from the first window for 5 cycles:
  - pix_ready_o=0 and win_o is held at 0,1,2,4,5,6,8,9,10.
  - After ready rises, pixel 11 is accepted and the next window is 1,2,3,5,6,7,9,10,11.
- Random pix_valid_i gaps (50%):
  - Window sequence is identical to the gap-free case.
  - frame_done_o pulses once, after pixel 15.
- Two back-to-back frames (values 0..15, then 100..115):
  - The second frame's first window is 100,101,102,104,105,106,108,109,110.
  - Exactly 8 windows in total.
- Reset asserted after pixel 9, then a new frame 0..15:
  - win_valid_o=0 during and after reset until pixel 10 of the new frame.
  - Windows then match scenario 1.
- IMG_W=3, IMG_H=3: a single window 0..8, then frame_done_o.
